// File: rtl/l4_out_unpacker.sv
// l4_out_unpacker: streams each precision-dependent field of a packed L4 result word out as one extended beat (clk, rst, prec/in_data/in_valid/in_ready in, res_data/res_idx/res_last/res_valid/res_ready out, prec_err pulse)
module l4_out_unpacker #(
  parameter int OUT_WIDTH = 64,
  parameter int OUTS_88   = 1,
  parameter int OUTS_84   = 2,
  parameter int OUTS_82   = 4,
  parameter int OUTS_44   = 4,
  parameter int OUTS_22   = 8,
  parameter int WIDTH_88  = 20,
  parameter int WIDTH_84  = 18,
  parameter int WIDTH_82  = 16,
  parameter int WIDTH_44  = 14,
  parameter int WIDTH_22  = 8,
  parameter int RES_WIDTH = 24,
  parameter int SIGNED    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 prec,
  input  logic [OUT_WIDTH-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [RES_WIDTH-1:0]       res_data,
  output logic [$clog2(OUTS_22)-1:0] res_idx,
  output logic                       res_last,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       prec_err
);
  localparam int IW = $clog2(OUTS_22);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_n;
  logic [OUT_WIDTH-1:0] word, word_n;
  logic [3:0] pq, pq_n;
  logic [IW-1:0] idx_n;
  logic acc, beat, legal, upd;
  function automatic logic is_legal(input logic [3:0] p);
    return p == 4'b0000 || p == 4'b0010 || p == 4'b0011 || p == 4'b1010 || p == 4'b1111;
  endfunction
  function automatic int n_of(input logic [3:0] p);
    return p == 4'b0000 ? OUTS_88 : p == 4'b0010 ? OUTS_84 : p == 4'b0011 ? OUTS_82 :
           p == 4'b1010 ? OUTS_44 : OUTS_22;
  endfunction
  function automatic int w_of(input logic [3:0] p);
    return p == 4'b0000 ? WIDTH_88 : p == 4'b0010 ? WIDTH_84 : p == 4'b0011 ? WIDTH_82 :
           p == 4'b1010 ? WIDTH_44 : WIDTH_22;
  endfunction
  // Move field k to the top of the word, then shift back down so the
  // extension (arithmetic or logical) fills everything above bit W-1.
  function automatic logic [RES_WIDTH-1:0] ext(input logic [OUT_WIDTH-1:0] wd, input logic [3:0] p,
                                               input logic [IW-1:0] k);
    logic [OUT_WIDTH-1:0] s;
    s = (wd >> (int'(k) * (OUT_WIDTH / n_of(p)))) << (OUT_WIDTH - w_of(p));
    if (SIGNED != 0) s = $unsigned($signed(s) >>> (OUT_WIDTH - w_of(p)));
    else s = s >> (OUT_WIDTH - w_of(p));
    return s[RES_WIDTH-1:0];
  endfunction
  assign res_valid = state == STREAM;
  // A new word is taken only while idle or as the last beat of the current word leaves.
  always_comb begin
    in_ready = state == IDLE || (res_last && res_ready);
    acc      = in_valid && in_ready;
    legal    = is_legal(prec);
    beat     = res_valid && res_ready;
    upd      = (acc && legal) || (beat && !res_last);
    state_n  = acc ? (legal ? STREAM : IDLE) : (beat && res_last) ? IDLE : state;
    word_n   = acc ? in_data : word;
    pq_n     = acc ? prec : pq;
    idx_n    = acc ? '0 : res_idx + IW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word     <= '0;
      pq       <= '0;
      res_data <= '0;
      res_idx  <= '0;
      res_last <= 1'b0;
      prec_err <= 1'b0;
    end else begin
      state    <= state_n;
      prec_err <= acc && !legal;
      if (upd) begin
        word     <= word_n;
        pq       <= pq_n;
        res_idx  <= idx_n;
        res_data <= ext(word_n, pq_n, idx_n);
        res_last <= int'(idx_n) == n_of(pq_n) - 1;
      end
    end
  end
endmodule
